// File: rtl/mioc_nor2_nmos_checker.sv
// MIOC NMOS NOR2 test-cell model and checker: produces the reference NOR value
// and scores the observed pad output, keeping pattern/coverage/mismatch statistics.
module mioc_nor2_nmos_checker #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in1,
  input  logic             in2,
  input  logic             sample,
  input  logic             z_obs,
  output logic             z,
  output logic             z_q,
  output logic [CNT_W-1:0] pattern_count,
  output logic [3:0]       coverage,
  output logic             all_covered,
  output logic             mismatch,
  output logic [ERR_W-1:0] mismatch_count,
  output logic [1:0]       first_fail_code,
  output logic             first_fail_valid
);

  logic [1:0]       code;
  logic             expected;
  logic             fail;

  logic             z_q_reg;
  logic [CNT_W-1:0] pattern_count_reg, pattern_count_next;
  logic [3:0]       coverage_reg, coverage_next;
  logic             mismatch_reg, mismatch_next;
  logic [ERR_W-1:0] mismatch_count_reg, mismatch_count_next;
  logic [1:0]       first_fail_code_reg, first_fail_code_next;
  logic             first_fail_valid_reg, first_fail_valid_next;

  assign code     = {in1, in2};
  assign expected = ~(in1 | in2);
  assign fail     = sample && (z_obs != expected);

  // Sticky coverage: each bit latches once its input code is sampled.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cov
      assign coverage_next[gi] = coverage_reg[gi] | (sample && (code == 2'(gi)));
    end
  endgenerate

  always_comb begin
    pattern_count_next    = pattern_count_reg;
    mismatch_next         = fail;
    mismatch_count_next   = mismatch_count_reg;
    first_fail_code_next  = first_fail_code_reg;
    first_fail_valid_next = first_fail_valid_reg;
    if (sample && !(&pattern_count_reg))
      pattern_count_next = pattern_count_reg + 1'b1;
    if (fail) begin
      if (!(&mismatch_count_reg))
        mismatch_count_next = mismatch_count_reg + 1'b1;
      // Only the first failing code is kept for diagnosis.
      if (!first_fail_valid_reg) begin
        first_fail_code_next  = code;
        first_fail_valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q_reg              <= 1'b0;
      pattern_count_reg    <= '0;
      coverage_reg         <= '0;
      mismatch_reg         <= 1'b0;
      mismatch_count_reg   <= '0;
      first_fail_code_reg  <= '0;
      first_fail_valid_reg <= 1'b0;
    end else begin
      z_q_reg              <= expected;
      pattern_count_reg    <= pattern_count_next;
      coverage_reg         <= coverage_next;
      mismatch_reg         <= mismatch_next;
      mismatch_count_reg   <= mismatch_count_next;
      first_fail_code_reg  <= first_fail_code_next;
      first_fail_valid_reg <= first_fail_valid_next;
    end
  end

  assign z                = expected;
  assign z_q              = z_q_reg;
  assign pattern_count    = pattern_count_reg;
  assign coverage         = coverage_reg;
  assign all_covered      = &coverage_reg;
  assign mismatch         = mismatch_reg;
  assign mismatch_count   = mismatch_count_reg;
  assign first_fail_code  = first_fail_code_reg;
  assign first_fail_valid = first_fail_valid_reg;

endmodule

// File: tb/tb_mioc_nor2_nmos_checker.sv
// Directed bench for mioc_nor2_nmos_checker: vector table plus a long
// constant-fault run for mismatch-counter saturation.
module tb_mioc_nor2_nmos_checker;

  logic        clk = 1'b0;
  logic        rst, in1, in2, sample, z_obs;
  logic        z, z_q, all_covered, mismatch, first_fail_valid;
  logic [15:0] pattern_count;
  logic [3:0]  coverage;
  logic [7:0]  mismatch_count;
  logic [1:0]  first_fail_code;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mioc_nor2_nmos_checker #(.CNT_W(16), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .sample(sample), .z_obs(z_obs),
    .z(z), .z_q(z_q), .pattern_count(pattern_count), .coverage(coverage),
    .all_covered(all_covered), .mismatch(mismatch), .mismatch_count(mismatch_count),
    .first_fail_code(first_fail_code), .first_fail_valid(first_fail_valid)
  );

  typedef struct {
    logic        rst, a, b, smp, zo;
    logic        ez, ezq;
    logic [15:0] epc;
    logic [3:0]  ecov;
    logic        eall, emm;
    logic [7:0]  emc;
    logic [1:0]  effc;
    logic        effv;
  } vec_t;

  vec_t vec [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic b, input logic s, input logic zo);
    rst = r; in1 = a; in2 = b; sample = s; z_obs = zo;
  endtask

  initial begin
    //            rst a b s zo  z zq  pc  cov     all mm mc   ffc    ffv
    vec[0]  = '{1, 0,0,1,0, 1,0, 16'd0, 4'b0000, 0,0, 8'd0, 2'b00, 0};
    vec[1]  = '{0, 0,0,1,1, 1,1, 16'd1, 4'b0001, 0,0, 8'd0, 2'b00, 0};
    vec[2]  = '{0, 0,1,1,0, 0,0, 16'd2, 4'b0011, 0,0, 8'd0, 2'b00, 0};
    vec[3]  = '{0, 1,0,1,0, 0,0, 16'd3, 4'b0111, 0,0, 8'd0, 2'b00, 0};
    vec[4]  = '{0, 1,1,1,0, 0,0, 16'd4, 4'b1111, 1,0, 8'd0, 2'b00, 0};
    vec[5]  = '{0, 1,0,1,1, 0,0, 16'd5, 4'b1111, 1,1, 8'd1, 2'b10, 1};
    vec[6]  = '{0, 1,0,0,1, 0,0, 16'd5, 4'b1111, 1,0, 8'd1, 2'b10, 1};
    vec[7]  = '{0, 0,0,1,0, 1,1, 16'd6, 4'b1111, 1,1, 8'd2, 2'b10, 1};
    vec[8]  = '{0, 0,0,0,0, 1,1, 16'd6, 4'b1111, 1,0, 8'd2, 2'b10, 1};
    vec[9]  = '{1, 1,0,1,1, 0,0, 16'd0, 4'b0000, 0,0, 8'd0, 2'b00, 0};
    vec[10] = '{0, 0,1,0,1, 0,0, 16'd0, 4'b0000, 0,0, 8'd0, 2'b00, 0};
    vec[11] = '{0, 0,0,0,0, 1,1, 16'd0, 4'b0000, 0,0, 8'd0, 2'b00, 0};
    vec[12] = '{0, 1,1,0,1, 0,0, 16'd0, 4'b0000, 0,0, 8'd0, 2'b00, 0};
    vec[13] = '{0, 1,0,0,0, 0,0, 16'd0, 4'b0000, 0,0, 8'd0, 2'b00, 0};

    drive(1, 0, 0, 0, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      drive(vec[i].rst, vec[i].a, vec[i].b, vec[i].smp, vec[i].zo);
      #1;
      check("z", 32'(z), 32'(vec[i].ez));
      @(posedge clk); #1;
      check("z_q", 32'(z_q), 32'(vec[i].ezq));
      check("pattern_count", 32'(pattern_count), 32'(vec[i].epc));
      check("coverage", 32'(coverage), 32'(vec[i].ecov));
      check("all_covered", 32'(all_covered), 32'(vec[i].eall));
      check("mismatch", 32'(mismatch), 32'(vec[i].emm));
      check("mismatch_count", 32'(mismatch_count), 32'(vec[i].emc));
      check("first_fail_code", 32'(first_fail_code), 32'(vec[i].effc));
      check("first_fail_valid", 32'(first_fail_valid), 32'(vec[i].effv));
      $display("vec %0d: rst=%0b in=%0b%0b sample=%0b z_obs=%0b -> z_q=%0b pc=%0d cov=%4b mm=%0b mc=%0d ffc=%2b ffv=%0b",
               i, vec[i].rst, vec[i].a, vec[i].b, vec[i].smp, vec[i].zo,
               z_q, pattern_count, coverage, mismatch, mismatch_count, first_fail_code, first_fail_valid);
    end

    // 300 back-to-back stuck-high samples at code 11: mismatch_count saturates at 255.
    drive(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int i = 1; i <= 300; i++) begin
      drive(0, 1, 1, 1, 1);
      @(posedge clk); #1;
      if (i == 254 || i == 255 || i == 256 || i == 300) begin
        check("sat_mismatch_count", 32'(mismatch_count), (i < 255) ? 32'(i) : 32'd255);
        check("sat_pattern_count", 32'(pattern_count), 32'(i));
        check("sat_mismatch", 32'(mismatch), 32'd1);
        $display("sat cycle %0d: pc=%0d mc=%0d mm=%0b", i, pattern_count, mismatch_count, mismatch);
      end
    end
    check("sat_first_fail_code", 32'(first_fail_code), 32'd3);
    check("sat_coverage", 32'(coverage), 32'b1000);
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("sat_idle_mismatch", 32'(mismatch), 32'd0);
    check("sat_idle_mismatch_count", 32'(mismatch_count), 32'd255);
    $display("sat idle: pc=%0d mc=%0d mm=%0b", pattern_count, mismatch_count, mismatch);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
